// File: rtl/sift_lb_pkg.sv
// Shared types and constants for the SIFT line-buffer sequencer.
package sift_lb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ZPUSH,
    RD,
    LAND,
    HOLD,
    DONE
  } lb_state_t;

  localparam int LB_DEPTH       = 10;
  localparam int LB_GROUP_DEPTH = 2;
  localparam int LB_ROW_BITS    = 5120;

endpackage

// File: rtl/line_buffer_ctrl.sv
// Fills the 10-row line buffer from row SRAM and hands row windows downstream.
// Zero padding rows above/below the image exist only when LB_CTRL_PAD_EN is defined.
module line_buffer_ctrl
  import sift_lb_pkg::*;
#(
  parameter int ROWS = 480,
  parameter int PAD  = 4,
  parameter int AW   = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  output logic          sram_re,
  output logic [AW-1:0] sram_addr,
  output logic          buffer_mode,
  output logic          buffer_we,
  output logic          fill_zero,
  output logic          window_valid,
  input  logic          window_ready,
  output logic [AW-1:0] window_idx,
  output logic          busy,
  output logic          done
);

`ifdef LB_CTRL_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  localparam int PAD_EFF = PAD_ON ? PAD : 0;

  lb_state_t     state, state_nxt;
  logic [3:0]    push_cnt, push_upd;
  logic [AW-1:0] row_cnt, row_upd;
  logic          push_now, more_rows, primed, zero_next, has_next;
  lb_state_t     next_push;

  // Counter values as they will be after this cycle; the next push is decided from them.
  assign push_now  = (state == LAND) || (state == ZPUSH);
  assign row_upd   = (state == LAND) ? row_cnt + AW'(1) : row_cnt;
  assign push_upd  = (push_now && push_cnt < 4'(LB_DEPTH)) ? push_cnt + 4'd1 : push_cnt;
  assign more_rows = int'(row_upd) < ROWS;
  assign primed    = int'(push_upd) >= (buffer_mode ? LB_GROUP_DEPTH : LB_DEPTH);

`ifdef LB_CTRL_PAD_EN
  localparam int PW = $clog2(2 * PAD_EFF + 2);
  logic [PW-1:0] pad_cnt, pad_upd;

  assign pad_upd   = (state == ZPUSH) ? pad_cnt + PW'(1) : pad_cnt;
  // Top pads come first; trailing pads only once every SRAM row has landed.
  assign zero_next = !buffer_mode &&
                     ((int'(pad_upd) < PAD_EFF) ||
                      (!more_rows && int'(pad_upd) < 2 * PAD_EFF));
  assign fill_zero = (state == ZPUSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_cnt <= '0;
    end else if (state == IDLE && start) begin
      pad_cnt <= '0;
    end else begin
      pad_cnt <= pad_upd;
    end
  end
`else
  assign zero_next = 1'b0;
  assign fill_zero = 1'b0;
`endif

  assign has_next  = zero_next || more_rows;
  assign next_push = zero_next ? ZPUSH : RD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      buffer_mode  <= 1'b0;
      push_cnt     <= '0;
      row_cnt      <= '0;
      window_idx   <= '0;
      window_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      window_valid <= (state_nxt == HOLD);
      if (state == IDLE && start) begin
        buffer_mode <= mode;
        push_cnt    <= '0;
        row_cnt     <= '0;
        window_idx  <= '0;
      end else begin
        push_cnt <= push_upd;
        row_cnt  <= row_upd;
        if (state == HOLD && window_ready) begin
          window_idx <= window_idx + AW'(1);
        end
      end
    end
  end

  // Until primed, pushes run back-to-back; afterwards every push waits in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (!mode && PAD_EFF > 0) ? ZPUSH : RD;
        end
      end
`ifdef LB_CTRL_PAD_EN
      ZPUSH: state_nxt = primed ? HOLD : next_push;
`endif
      RD:    state_nxt = LAND;
      LAND:  state_nxt = primed ? HOLD : next_push;
      HOLD: begin
        if (window_ready) begin
          state_nxt = has_next ? next_push : DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sram_re   = (state == RD);
  assign sram_addr = (state == RD) ? row_cnt : '0;
  assign buffer_we = push_now;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: cycle vectors plus randomized frames
// checked against a push-list / window-count model.
module tb_line_buffer_ctrl;

  localparam int ROWS = 12;
  localparam int PAD  = 4;
  localparam int AW   = 9;
`ifdef LB_CTRL_PAD_EN
  localparam int EP = PAD;
`else
  localparam int EP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, mode, window_ready;
  logic          sram_re, buffer_mode, buffer_we, fill_zero, window_valid, busy, done;
  logic [AW-1:0] sram_addr, window_idx;

  int checks = 0;
  int errors = 0;

  line_buffer_ctrl #(.ROWS(ROWS), .PAD(PAD), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .sram_re(sram_re), .sram_addr(sram_addr), .buffer_mode(buffer_mode),
    .buffer_we(buffer_we), .fill_zero(fill_zero), .window_valid(window_valid),
    .window_ready(window_ready), .window_idx(window_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit start; bit mode; bit ready;
    bit re; int addr; bit bm; bit we; bit fz; bit valid; int idx; bit busy; bit done;
  } vec_t;

  function automatic logic [24:0] outv();
    return {sram_re, sram_addr, buffer_mode, buffer_we, fill_zero, window_valid,
            window_idx, busy, done};
  endfunction

  function automatic logic [24:0] packExp(input vec_t v);
    return {v.re, AW'(v.addr), v.bm, v.we, v.fz, v.valid, AW'(v.idx), v.busy, v.done};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    start        = v.start;
    mode         = v.mode;
    window_ready = v.ready;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vector%0d", i), 64'(outv()), 64'(packExp(v)));
  endtask

  // Runs one frame; with rstAt >= 0 the frame is cut by a reset at that window.
  task automatic runFrame(input bit m, input bit allReady, input bit bpEn,
                          input int spurCyc, input int rstAt);
    int  expQ[$];
    int  gotQ[$];
    int  depth, nWin, sumCost, cyc, accepted, lastAcc, doneCyc, bpLeft, prevAddr;
    bit  prevRe, prevWe, prevValid, bpDone, bpActive, seqOk, wasReset;

    depth = m ? 2 : 10;
    if (!m) for (int i = 0; i < EP; i++) expQ.push_back(-1);
    for (int r = 0; r < ROWS; r++) expQ.push_back(r);
    if (!m) for (int i = 0; i < EP; i++) expQ.push_back(-1);
    nWin    = expQ.size() - depth + 1;
    sumCost = (m ? 0 : 2 * EP) + 2 * ROWS;

    cyc = 0; accepted = 0; lastAcc = -10; doneCyc = -1; bpLeft = 0;
    prevRe = 0; prevWe = 0; prevValid = 0; prevAddr = 0;
    bpDone = 0; bpActive = 0; wasReset = 0;

    start = 1; mode = m; window_ready = allReady;
    @(posedge clk); #1;
    start = 0; mode = 1'($urandom_range(0, 1));

    while (1) begin
      cyc++;
      checkOutput("fz_without_we", 64'(fill_zero & ~buffer_we), 64'(0));
      checkOutput("buffer_mode", 64'(buffer_mode), 64'(m));
      if (bpActive) checkOutput("bp_valid_held", 64'(window_valid), 64'(1));
      if (buffer_we && !fill_zero) begin
        checkOutput("we_latency", 64'(prevRe), 64'(1));
        gotQ.push_back(prevAddr);
      end else if (buffer_we) begin
        gotQ.push_back(-1);
      end
      if (sram_re) checkOutput("addr_range", 64'(int'(sram_addr) < ROWS), 64'(1));
      if (window_valid) begin
        checkOutput("window_idx", 64'(window_idx), 64'(accepted));
        checkOutput("hold_quiet", 64'(sram_re | buffer_we), 64'(0));
        if (!prevValid) checkOutput("valid_rise", 64'(prevWe), 64'(1));
        if (!prevValid && accepted == 0)
          checkOutput("prime_depth", 64'(gotQ.size()), 64'(depth));
      end
      prevRe = sram_re; prevAddr = int'(sram_addr); prevWe = buffer_we;
      prevValid = window_valid;

      if (done) begin
        doneCyc = cyc;
        break;
      end
      if (cyc >= 2000) begin
        checkOutput("frame_timeout", 64'(0), 64'(1));
        break;
      end
      if (rstAt >= 0 && accepted == rstAt && window_valid) begin
        window_ready = 0;
        rst_n = 0;
        @(posedge clk); #1;
        checkOutput("reset_mid_frame", 64'(outv()), 64'(0));
        rst_n = 1;
        @(posedge clk); #1;
        checkOutput("reset_idle", 64'(outv()), 64'(0));
        wasReset = 1;
        break;
      end

      window_ready = allReady ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (bpEn && !bpDone && accepted == 3 && window_valid) begin
        bpLeft = 7;
        bpDone = 1;
      end
      bpActive = 0;
      if (bpLeft > 0) begin
        window_ready = 0;
        bpLeft--;
        bpActive = 1;
      end
      if (window_valid && window_ready) begin
        accepted++;
        lastAcc = cyc;
      end
      if (cyc == spurCyc) begin
        start = 1; mode = 1;
      end else begin
        start = 0;
      end
      @(posedge clk); #1;
    end
    start = 0;

    if (!wasReset) begin
      checkOutput("window_count", 64'(accepted), 64'(nWin));
      checkOutput("done_after_accept", 64'(doneCyc), 64'(lastAcc + 1));
      checkOutput("busy_at_done", 64'(busy), 64'(0));
      checkOutput("push_count", 64'(gotQ.size()), 64'(expQ.size()));
      seqOk = (gotQ.size() == expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
        if (gotQ[i] != expQ[i]) seqOk = 0;
      checkOutput("push_sequence", 64'(seqOk), 64'(1));
      if (allReady) checkOutput("frame_cycles", 64'(doneCyc), 64'(sumCost + nWin + 1));
      window_ready = 0;
      @(posedge clk); #1;
      checkOutput("back_to_idle", 64'({sram_re, buffer_we, window_valid, busy, done}), 64'(0));
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0,0,0, 0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,1,0, 1,0,1,0,0,0,0,1,0};
    tbl[2]  = '{0,0,1, 0,0,1,1,0,0,0,1,0};
    tbl[3]  = '{0,0,1, 1,1,1,0,0,0,0,1,0};
    tbl[4]  = '{0,0,0, 0,0,1,1,0,0,0,1,0};
    tbl[5]  = '{0,0,0, 0,0,1,0,0,1,0,1,0};
    tbl[6]  = '{0,0,0, 0,0,1,0,0,1,0,1,0};
    tbl[7]  = '{0,0,1, 1,2,1,0,0,0,1,1,0};
    tbl[8]  = '{1,0,0, 0,0,1,1,0,0,1,1,0};
    tbl[9]  = '{0,0,0, 0,0,1,0,0,1,1,1,0};
    tbl[10] = '{0,0,1, 1,3,1,0,0,0,2,1,0};

    rst_n = 0; start = 0; mode = 0; window_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 64'(outv()), 64'(0));
    rst_n = 1;

    for (int i = 0; i < 11; i++) applyStimulus(tbl[i], i);

    rst_n = 0; start = 0; window_ready = 0;
    @(posedge clk); #1;
    checkOutput("table_reset", 64'(outv()), 64'(0));
    rst_n = 1;
    @(posedge clk); #1;

    runFrame(1'b0, 1'b1, 1'b0, 5, -1);
    runFrame(1'b1, 1'b1, 1'b0, -1, -1);
    runFrame(1'b1, 1'b0, 1'b1, 8, -1);
    runFrame(1'b1, 1'b0, 1'b0, -1, 5);
    runFrame(1'b0, 1'b0, 1'b0, 12, -1);
    for (int k = 0; k < 3; k++)
      runFrame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
               int'($urandom_range(3, 20)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer that fills the 10-row line buffer from row SRAM and hands complete row windows to the downstream filter stage (Gaussian blur / match). It issues SRAM row reads, drives the buffer's `buffer_mode`, `buffer_we` and `fill_zero` controls, and inserts zero padding rows above and below the image. It exposes a valid/ready window handshake downstream.

## Interface
- `ROWS`, 480: image height in rows; must be ≥ 10.
- `PAD`, 4: zero rows pushed before and after the image (mode 0 only).
- `AW`, 9: SRAM row address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
- `mode`  in  1  sampled on `start`; 0 = 10-deep single chain, 1 = 5 groups of 2.
- `sram_re`  out  1  row read strobe.
- `sram_addr`  out  AW  row address; applies to all 5 banks.
- `buffer_mode`  out  1  latched mode, to the buffer.
- `buffer_we`  out  1  buffer shift/load strobe.
- `fill_zero`  out  1  zero-row push; always asserted together with `buffer_we`.
- `window_valid`  out  1  buffer holds a complete window.
- `window_ready`  in  1  downstream accepts the window.
- `window_idx`  out  AW  index of the current window, starting at 0.
- `busy`  out  1  high from `start` until `done`.
- `done`  out  1  one-cycle pulse after the last window is accepted.

## Operation
- States: IDLE, ZPUSH, RD, LAND, HOLD, DONE.
- **IDLE**
  - On `start`: latch `mode` into `buffer_mode`.
  - Clear `push_cnt`, `row_cnt`, `pad_cnt` and `window_idx`.
  - Next state: ZPUSH if mode 0 and PAD > 0; otherwise RD.
- **ZPUSH**
  - Assert `fill_zero` and `buffer_we` for 1 cycle; `push_cnt` increments.
  - Pads are top pads while `row_cnt` < ROWS, trailing pads after that.
- **RD**
  - Assert `sram_re` with `sram_addr` = `row_cnt`.
- **LAND**
  - Assert `buffer_we`; SRAM data lands in the buffer.
  - `row_cnt` and `push_cnt` increment.
- **Priming**
  - Window is complete when `push_cnt` reaches 10 (mode 0) or 2 (mode 1).
  - Until then, pushes run back-to-back with no handshake.
- **HOLD** (entered after each push once primed)
  - `window_valid` is high and stays high until `window_ready`.
  - On accept: `window_idx` increments; next state is the next push, or DONE if that was the last window.
- **Push order, mode 0**
  - PAD zeros, then ROWS SRAM rows, then PAD zeros.
  - Total 2·PAD + ROWS pushes; window count = 2·PAD + ROWS − 9.
- **Push order, mode 1**
  - ROWS SRAM rows, no pads; window count = ROWS − 1.
- **DONE**
  - Pulse `done`, drop `busy`, return to IDLE.
- **Boundary conditions**
  - `start` while busy: ignored.
  - `window_ready` outside HOLD: ignored.
  - `mode` changes after `start`: no effect until the next frame.
  - `sram_addr` never exceeds ROWS − 1.

## Timing
- Reset: all outputs 0, state IDLE.
- SRAM read latency is 1: `sram_re` in cycle t, `buffer_we` in cycle t+1.
- `window_valid` rises in the cycle after the completing `buffer_we`; it is registered.
- Per-window cost after accept:
  - SRAM row: 2 cycles (RD, LAND), then HOLD.
  - Zero row: 1 cycle (ZPUSH), then HOLD.
- `done` fires the cycle after the final accept.
- Throughput with `window_ready` held high: one window per 3 cycles for SRAM rows, one per 2 cycles for zero rows.
- Reset mid-frame: the next clock returns to IDLE with all outputs 0. The buffer contents are reset by the buffer itself on the same `rst_n`.

## Configuration
- `LB_CTRL_PAD_EN` defined:
  - ZPUSH and `pad_cnt` exist; padding behaves as above.
- `LB_CTRL_PAD_EN` undefined:
  - PAD is treated as 0 in both modes; ZPUSH and `pad_cnt` are removed.
  - `fill_zero` is tied 0.
  - Mode 0 window count = ROWS − 9.

## Structure
- Shared package `sift_lb_pkg` holds:
  - the state enum `lb_state_t`;
  - `LB_DEPTH` = 10, `LB_GROUP_DEPTH` = 2, `LB_ROW_BITS` = 5120.
- Single module; no sub-module is warranted.

## Test plan
- **Mode 0, ROWS=12, PAD=4, ready held 1**
  - Expect 20 pushes: 4 zero, 12 SRAM, 4 zero.
  - Expect 11 windows, `window_idx` 0..10.
  - `done` fires 1 cycle after the 11th accept; `sram_addr` sequence is 0..11.
- **Mode 1, ROWS=12**
  - Expect no `fill_zero`.
  - First `window_valid` in the cycle after the 2nd `buffer_we`.
  - Expect 11 windows.
- **Backpressure**
  - Hold `window_ready` low for 7 cycles at window 3.
  - `window_valid` stays high, no `sram_re` or `buffer_we` occurs, and `window_idx` stays 3.
- **Latency**
  - For every SRAM push, `buffer_we` is exactly 1 cycle after `sram_re`.
  - `fill_zero` is never high without `buffer_we`.
- **Reset mid-frame**
  - Pulse `rst_n` low during window 5.
  - Next cycle: all outputs 0, IDLE.
  - A new `start` then runs a full, correct frame.
- **Spurious start**
  - Pulse `start` with `mode`=1 during a mode 0 frame.
  - No effect: `buffer_mode` stays 0 and the window count is unchanged.
